// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the transmit sequencer.
package tx_seq_pkg;

  localparam int unsigned IqWidth  = 18;
  localparam int unsigned PhiWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StRampUp,
    StOn,
    StRampDown,
    StTail
  } tx_state_e;

  // Tuning-word updates are only allowed where the carrier envelope is flat.
  function automatic logic phi_update_ok(tx_state_e st);
    return !((st == StRampUp) || (st == StRampDown));
  endfunction

endpackage

// File: rtl/tx_gain_mult.sv
// Two-stage signed sample x unsigned gain scaler: product register, then floor shift.
module tx_gain_mult
  import tx_seq_pkg::*;
#(
  parameter int unsigned RampBits = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic signed [IqWidth-1:0]  sample_i,
  input  logic        [RampBits:0]   gain_i,
  output logic signed [IqWidth-1:0]  scaled_o
);

  localparam int unsigned ProdW = IqWidth + RampBits + 2;

  logic signed [ProdW-1:0]   sample_ext;
  logic signed [ProdW-1:0]   gain_ext;
  logic signed [ProdW-1:0]   prod_d, prod_q;
  logic signed [IqWidth-1:0] scaled_d, scaled_q;

  always_comb begin
    sample_ext = {{(ProdW - IqWidth){sample_i[IqWidth-1]}}, sample_i};
    gain_ext   = {{(ProdW - RampBits - 1){1'b0}}, gain_i};
    prod_d     = sample_ext * gain_ext;
    // Arithmetic shift floors toward -inf; unity gain returns the sample exactly.
    scaled_d   = IqWidth'(prod_q >>> RampBits);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q   <= '0;
      scaled_q <= '0;
    end else begin
      prod_q   <= prod_d;
      scaled_q <= scaled_d;
    end
  end

  assign scaled_o = scaled_q;

endmodule

// File: rtl/tx_seq_ctrl.sv
// TX sequencer: PA lead/tail timing, linear carrier gain ramp, I/Q scaling and
// tuning-word updates deferred until the envelope is flat.
module tx_seq_ctrl
  import tx_seq_pkg::*;
#(
  parameter int unsigned RampBits = 10,
  parameter int unsigned RampDiv  = 1,
  parameter int unsigned PaLead   = 64,
  parameter int unsigned PaTail   = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tx_req_i,
  input  logic        [PhiWidth-1:0] phi_in_i,
  input  logic                       phi_load_i,
  input  logic signed [IqWidth-1:0]  i_in_i,
  input  logic signed [IqWidth-1:0]  q_in_i,
  output logic signed [IqWidth-1:0]  i_data_o,
  output logic signed [IqWidth-1:0]  q_data_o,
  output logic        [PhiWidth-1:0] phi_o,
  output logic                       pa_en_o,
  output logic                       tx_active_o,
  output logic                       ramp_busy_o
);

  localparam logic [RampBits:0] GainFull = {1'b1, {RampBits{1'b0}}};
  localparam logic [15:0]       LeadLoad = 16'(PaLead - 1);
  localparam logic [15:0]       TailLoad = 16'(PaTail - 1);
  localparam logic [15:0]       DivLast  = 16'(RampDiv - 1);

  tx_state_e state_d, state_q;
  logic [15:0]         cnt_d, cnt_q;
  logic [15:0]         presc_d, presc_q;
  logic [RampBits:0]   g_d, g_q, g_dly_q;
  logic [PhiWidth-1:0] pend_d, pend_q;
  logic                pend_vld_d, pend_vld_q;
  logic [PhiWidth-1:0] phi_d, phi_q;
  logic                pa_en_d, pa_en_q;
  logic                tx_active_d, tx_active_q;
  logic                ramp_busy_d, ramp_busy_q;
  logic                tick;

  assign tick = (presc_q == DivLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    unique case (state_q)
      StIdle: begin
        g_d = '0;
        if (tx_req_i) begin
          state_d = StLead;
          cnt_d   = LeadLoad;
        end
      end
      StLead: begin
        if (!tx_req_i) begin
          state_d = StTail;
          cnt_d   = TailLoad;
        end else if (cnt_q == '0) begin
          state_d = StRampUp;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StRampUp: begin
        // A direction change holds g for the transition cycle: at most one step per tick.
        if (!tx_req_i) begin
          state_d = StRampDown;
        end else if (tick) begin
          g_d = g_q + 1'b1;
          if (g_d == GainFull) state_d = StOn;
        end
      end
      StOn: begin
        g_d = GainFull;
        if (!tx_req_i) state_d = StRampDown;
      end
      StRampDown: begin
        if (tx_req_i) begin
          state_d = StRampUp;
        end else if (tick) begin
          g_d = g_q - 1'b1;
          if (g_d == '0) begin
            state_d = StTail;
            cnt_d   = TailLoad;
          end
        end
      end
      StTail: begin
        if (tx_req_i) begin
          state_d = StRampUp;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    presc_d     = ((state_d != state_q) || tick) ? '0 : presc_q + 16'd1;
    pa_en_d     = (state_d != StIdle);
    ramp_busy_d = (state_d == StRampUp) || (state_d == StRampDown);
    tx_active_d = (g_d != '0);

    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    phi_d      = phi_q;
    if (phi_load_i) begin
      pend_d     = phi_in_i;
      pend_vld_d = 1'b1;
    end
    // Gate on the next state so the update lands in the first flat-envelope cycle.
    if (phi_update_ok(state_d) && pend_vld_d) begin
      phi_d      = pend_d;
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      presc_q     <= '0;
      g_q         <= '0;
      g_dly_q     <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      phi_q       <= '0;
      pa_en_q     <= 1'b0;
      tx_active_q <= 1'b0;
      ramp_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      g_q         <= g_d;
      g_dly_q     <= g_q;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      phi_q       <= phi_d;
      pa_en_q     <= pa_en_d;
      tx_active_q <= tx_active_d;
      ramp_busy_q <= ramp_busy_d;
    end
  end

  tx_gain_mult #(
    .RampBits (RampBits)
  ) u_mult_i (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sample_i (i_in_i),
    .gain_i   (g_dly_q),
    .scaled_o (i_data_o)
  );

  tx_gain_mult #(
    .RampBits (RampBits)
  ) u_mult_q (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sample_i (q_in_i),
    .gain_i   (g_dly_q),
    .scaled_o (q_data_o)
  );

  assign phi_o       = phi_q;
  assign pa_en_o     = pa_en_q;
  assign tx_active_o = tx_active_q;
  assign ramp_busy_o = ramp_busy_q;

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// Directed bench for tx_seq_ctrl (RampBits=4, RampDiv=1, PaLead=4, PaTail=3) plus a
// standalone 10-bit gain scaler.
module tb_tx_seq_ctrl;
  import tx_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               tx_req;
  logic [31:0]        phi_in;
  logic               phi_load;
  logic signed [17:0] i_in, q_in;
  logic signed [17:0] i_data, q_data;
  logic [31:0]        phi;
  logic               pa_en, tx_active, ramp_busy;

  logic signed [17:0] m_sample;
  logic [10:0]        m_gain;
  logic signed [17:0] m_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tx_seq_ctrl #(
    .RampBits (4),
    .RampDiv  (1),
    .PaLead   (4),
    .PaTail   (3)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tx_req_i    (tx_req),
    .phi_in_i    (phi_in),
    .phi_load_i  (phi_load),
    .i_in_i      (i_in),
    .q_in_i      (q_in),
    .i_data_o    (i_data),
    .q_data_o    (q_data),
    .phi_o       (phi),
    .pa_en_o     (pa_en),
    .tx_active_o (tx_active),
    .ramp_busy_o (ramp_busy)
  );

  tx_gain_mult #(
    .RampBits (10)
  ) u_mult (
    .clk_i    (clk),
    .rst_i    (rst),
    .sample_i (m_sample),
    .gain_i   (m_gain),
    .scaled_o (m_out)
  );

  task automatic check_eq(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int samp_tab [6] = '{131071, -131072, -1, -5, 131071, -131072};
  int gain_tab [6] = '{512, 512, 512, 1024, 1024, 0};
  int exp_tab  [6] = '{65535, -65536, -1, -5, 131071, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, nb, steps;
    longint prev;

    rst = 1'b1; tx_req = 1'b0; phi_in = '0; phi_load = 1'b0;
    i_in = 18'sd1000; q_in = -18'sd1000;
    m_sample = '0; m_gain = '0;
    tick(); tick();
    check_eq("rst_pa_en", longint'(pa_en), 0);
    check_eq("rst_tx_active", longint'(tx_active), 0);
    check_eq("rst_ramp_busy", longint'(ramp_busy), 0);
    check_eq("rst_phi", longint'(phi), 0);
    check_eq("rst_i_data", longint'(i_data), 0);
    check_eq("rst_state", longint'(dut.state_q), longint'(StIdle));
    rst = 1'b0;

    // Key-up, with phase loads during the ramp
    tx_req = 1'b1;
    tick();
    check_eq("keyup_pa_en", longint'(pa_en), 1);
    check_eq("keyup_g_lead", longint'(dut.g_q), 0);
    n = 0;
    while (dut.g_q == '0 && n < 20) begin
      tick();
      n++;
    end
    check_eq("keyup_first_g", longint'(dut.g_q), 1);
    for (int k = 2; k <= 16; k++) begin
      phi_load = (k == 4) || (k == 11);
      phi_in   = (k == 4) ? 32'h1234_5678 : 32'h0ABC_DEF0;
      tick();
      phi_load = 1'b0;
      check_eq("keyup_g", longint'(dut.g_q), longint'(k));
      if (k == 5 || k == 15) check_eq("phase_hold", longint'(phi), 0);
    end
    check_eq("keyup_state_on", longint'(dut.state_q), longint'(StOn));
    check_eq("phase_first_on", longint'(phi), longint'(32'h0ABC_DEF0));
    check_eq("keyup_ramp_busy", longint'(ramp_busy), 0);
    check_eq("keyup_tx_active", longint'(tx_active), 1);
    tick(); tick(); tick();
    check_eq("on_i_data", longint'(i_data), 1000);
    check_eq("on_q_data", longint'(q_data), -1000);
    i_in = -18'sd77;
    tick();
    check_eq("lat_i_stage1", longint'(i_data), 1000);
    tick();
    check_eq("lat_i_stage2", longint'(i_data), -77);

    // Key-down
    tx_req = 1'b0;
    nb = 0; n = 0;
    while (tx_active && n < 40) begin
      tick();
      n++;
      if (ramp_busy) nb++;
    end
    check_eq("keydown_ramp_len", longint'(nb), 16);
    check_eq("keydown_g_zero", longint'(dut.g_q), 0);
    n = 0;
    while (pa_en && n < 10) begin
      n++;
      tick();
    end
    check_eq("keydown_tail_len", longint'(n), 3);
    check_eq("keydown_idle", longint'(dut.state_q), longint'(StIdle));

    // Abort mid-ramp and re-key
    tx_req = 1'b1;
    n = 0;
    while (dut.g_q != 5'd7 && n < 40) begin
      tick();
      n++;
    end
    check_eq("abort_reach7", longint'(dut.g_q), 7);
    tx_req = 1'b0;
    prev = 7; steps = 0; n = 0;
    while (dut.g_q != 5'd3 && n < 20) begin
      tick();
      n++;
      check_eq("abort_pa_en", longint'(pa_en), 1);
      if (longint'(dut.g_q) != prev) begin
        check_eq("abort_down_step", longint'(dut.g_q), prev - 1);
        prev = longint'(dut.g_q);
        steps++;
      end
    end
    check_eq("abort_down_steps", longint'(steps), 4);
    tx_req = 1'b1;
    steps = 0; n = 0;
    while (dut.g_q != 5'd6 && n < 20) begin
      tick();
      n++;
      check_eq("abort_pa_en", longint'(pa_en), 1);
      if (longint'(dut.g_q) != prev) begin
        check_eq("abort_up_step", longint'(dut.g_q), prev + 1);
        prev = longint'(dut.g_q);
        steps++;
      end
    end
    check_eq("abort_up_steps", longint'(steps), 3);

    // Reset during ramp-down
    n = 0;
    while (dut.state_q != StOn && n < 30) begin
      tick();
      n++;
    end
    check_eq("rst2_on", longint'(dut.state_q), longint'(StOn));
    tx_req = 1'b0;
    n = 0;
    while (dut.g_q != 5'd9 && n < 30) begin
      tick();
      n++;
    end
    check_eq("rst2_g9", longint'(dut.g_q), 9);
    check_eq("rst2_busy", longint'(ramp_busy), 1);
    rst = 1'b1;
    tick();
    check_eq("rst2_pa_en", longint'(pa_en), 0);
    check_eq("rst2_tx_active", longint'(tx_active), 0);
    check_eq("rst2_ramp_busy", longint'(ramp_busy), 0);
    check_eq("rst2_phi", longint'(phi), 0);
    check_eq("rst2_i_data", longint'(i_data), 0);
    check_eq("rst2_q_data", longint'(q_data), 0);
    check_eq("rst2_state", longint'(dut.state_q), longint'(StIdle));
    rst = 1'b0;
    tick();

    // Standalone 10-bit scaler: output trails the (sample, gain) pair by two clocks
    for (int j = 0; j <= 6; j++) begin
      if (j < 6) begin
        m_sample = 18'(samp_tab[j]);
        m_gain   = 11'(gain_tab[j]);
      end
      tick();
      if (j >= 1) check_eq("scale_out", longint'(m_out), longint'(exp_tab[j-1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_seq_ctrl.md
# tx_seq_ctrl

Transmit sequencer that sits between the TX baseband source and the quadrature TX mixer. It controls PA enable and keys the carrier with a linear amplitude ramp, so the carrier never starts or stops abruptly. It also scales the 18-bit I/Q samples by the ramp gain before they reach the mixer. Finally, it applies tuning-word (phi) updates only outside the ramps, so the keying envelope stays spectrally clean.

## Interface
Parameters:
- RAMP_BITS, default 10: gain resolution; full-scale (unity) gain = 2^RAMP_BITS.
- RAMP_DIV, default 1: clocks per gain step (range 1 to 65535).
- PA_LEAD, default 64: clocks of PA enable before the ramp-up starts (range 1 to 65535).
- PA_TAIL, default 64: clocks of PA enable held after the ramp-down ends (range 1 to 65535).

Ports:
- clk, in, 1: system clock. Single clock domain.
- rst, in, 1: synchronous, active-high reset.
- tx_req, in, 1: transmit request (PTT). Level-sensitive.
- phi_in, in, 32: new tuning word.
- phi_load, in, 1: one-cycle strobe that captures phi_in.
- i_in, in, 18 signed: baseband I sample.
- q_in, in, 18 signed: baseband Q sample.
- i_data, out, 18 signed: gain-scaled I, drives the mixer.
- q_data, out, 18 signed: gain-scaled Q, drives the mixer.
- phi, out, 32: tuning word, drives the mixer NCO.
- pa_en, out, 1: PA/T-R relay enable.
- tx_active, out, 1: high while gain is above 0.
- ramp_busy, out, 1: high in RAMP_UP and RAMP_DOWN.

## Operation
- All outputs are registered.
- Reset values: state IDLE, gain 0, i_data/q_data 0, phi 0, pa_en 0, tx_active 0, ramp_busy 0, pending flag 0.
- Gain register g is unsigned, RAMP_BITS+1 wide, range 0 to 2^RAMP_BITS.
- A "tick" is the cycle in which the prescaler equals RAMP_DIV-1. The prescaler clears on every state change.

States and transitions (evaluated every clock):
- IDLE:
  - g = 0 and pa_en = 0.
  - tx_req=1 → LEAD, loading the counter with PA_LEAD-1.
- LEAD:
  - pa_en = 1; the counter decrements.
  - Counter = 0 with tx_req=1 → RAMP_UP.
  - tx_req=0 → TAIL, loading the counter with PA_TAIL-1.
- RAMP_UP:
  - g += 1 on each tick.
  - The tick that makes g = 2^RAMP_BITS moves to ON.
  - tx_req=0 → RAMP_DOWN, starting from the current g (no gain discontinuity).
- ON:
  - g is held at full scale.
  - tx_req=0 → RAMP_DOWN.
- RAMP_DOWN:
  - g -= 1 on each tick.
  - The tick that makes g = 0 moves to TAIL, loading the counter with PA_TAIL-1.
  - tx_req=1 → RAMP_UP, starting from the current g.
- TAIL:
  - pa_en = 1; the counter decrements.
  - Counter = 0 → IDLE.
  - tx_req=1 → RAMP_UP directly (no second LEAD, since the PA is already on).

Scaling:
- i_data = (i_in × g) >>> RAMP_BITS, using an arithmetic shift (floor). Q is computed identically.
- The product width is 18+RAMP_BITS+2 signed bits.
- g = 2^RAMP_BITS must return i_in exactly.
- g = 0 must return exactly 0.

Phase handling:
- phi_load captures phi_in into a pending register and sets the pending flag.
- A later phi_load overwrites the pending value.
- The pending value transfers to phi on the first cycle in IDLE, LEAD, ON or TAIL, and the flag clears.
- During RAMP_UP and RAMP_DOWN, phi is held.
- A phi_load in an allowed state reaches phi on the next clock.

Other rules:
- rst mid-ramp overrides everything: the next cycle shows reset values, including pa_en = 0 at once.
- tx_active = (g ≠ 0), registered with g.

## Timing
- i_in/q_in to i_data/q_data: 2 clocks.
  - Stage 1 registers the product.
  - Stage 2 registers the shift.
  - g is delayed 1 clock internally so the gain and the sample stay aligned.
- tx_req to pa_en rising: 1 clock.
- pa_en rising to first g change: PA_LEAD clocks.
- Full ramp duration: 2^RAMP_BITS × RAMP_DIV clocks.
- g = 0 to pa_en falling: PA_TAIL clocks.
- tx_req toggling every cycle must not cause g to move more than 1 step per tick.

## Structure
- Package tx_seq_pkg holds:
  - the state enum (IDLE, LEAD, RAMP_UP, ON, RAMP_DOWN, TAIL);
  - the IQ width constant (18);
  - the phi width constant (32).
- Sub-module tx_gain_mult: 2-stage signed × unsigned scaler, instantiated twice (once for I, once for Q).
- Everything else (FSM, counters, phi pending logic) lives in tx_seq_ctrl.

## Test plan
Unless stated otherwise, the bench uses RAMP_BITS=4, RAMP_DIV=1, PA_LEAD=4, PA_TAIL=3.
- Key-up:
  - Stimulus: tx_req rises at cycle 0.
  - Required: pa_en=1 at cycle 1; g steps 1..16 over 16 clocks after the lead; state ON with i_data = i_in.
- Scaling:
  - Stimulus: RAMP_BITS=10, g=512; i_in=131071 then −131072.
  - Required: i_data = 65535 then −65536 (two clocks later).
- Abort mid-ramp:
  - Stimulus: drop tx_req at g=7 during RAMP_UP, then raise it again at g=3.
  - Required: g goes 6,5,4,3, then rises 4,5,…; pa_en never falls.
- Key-down:
  - Stimulus: release from ON.
  - Required: g reaches 0 after 16 clocks; pa_en falls 3 clocks later; state IDLE.
- Phase gating:
  - Stimulus: phi_load 0x12345678 during RAMP_UP, then 0x0ABCDEF0 before ON.
  - Required: phi stays unchanged until ON, then becomes 0x0ABCDEF0 in the first ON cycle.
- Reset:
  - Stimulus: rst at g=9 during RAMP_DOWN.
  - Required: the next clock shows all outputs 0, including phi.
